// File: rtl/mips_funct.sv
// Shared MIPS R-type funct codes and the multiply/divide unit state encoding.
// Imported by the EX-stage ALU decode and by the multiply/divide unit.
package mips_funct;

  localparam int NB_FUNCT = 6;

  localparam logic [NB_FUNCT-1:0] SLL_OP   = 6'b000000;
  localparam logic [NB_FUNCT-1:0] SRL_OP   = 6'b000010;
  localparam logic [NB_FUNCT-1:0] SRA_OP   = 6'b000011;
  localparam logic [NB_FUNCT-1:0] SLLV_OP  = 6'b000100;
  localparam logic [NB_FUNCT-1:0] SRLV_OP  = 6'b000110;
  localparam logic [NB_FUNCT-1:0] SRAV_OP  = 6'b000111;
  localparam logic [NB_FUNCT-1:0] MFHI_OP  = 6'b010000;
  localparam logic [NB_FUNCT-1:0] MTHI_OP  = 6'b010001;
  localparam logic [NB_FUNCT-1:0] MFLO_OP  = 6'b010010;
  localparam logic [NB_FUNCT-1:0] MTLO_OP  = 6'b010011;
  localparam logic [NB_FUNCT-1:0] MULT_OP  = 6'b011000;
  localparam logic [NB_FUNCT-1:0] MULTU_OP = 6'b011001;
  localparam logic [NB_FUNCT-1:0] DIV_OP   = 6'b011010;
  localparam logic [NB_FUNCT-1:0] DIVU_OP  = 6'b011011;
  localparam logic [NB_FUNCT-1:0] ADD_OP   = 6'b100000;
  localparam logic [NB_FUNCT-1:0] ADDU_OP  = 6'b100001;
  localparam logic [NB_FUNCT-1:0] SUB_OP   = 6'b100010;
  localparam logic [NB_FUNCT-1:0] SUBU_OP  = 6'b100011;
  localparam logic [NB_FUNCT-1:0] AND_OP   = 6'b100100;
  localparam logic [NB_FUNCT-1:0] OR_OP    = 6'b100101;
  localparam logic [NB_FUNCT-1:0] XOR_OP   = 6'b100110;
  localparam logic [NB_FUNCT-1:0] NOR_OP   = 6'b100111;
  localparam logic [NB_FUNCT-1:0] SLT_OP   = 6'b101010;
  localparam logic [NB_FUNCT-1:0] SLTU_OP  = 6'b101011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } muldiv_state_e;

  function automatic logic is_signed_op(input logic [NB_FUNCT-1:0] op);
    return (op == MULT_OP) || (op == DIV_OP);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation: magnitude extraction at operand
// latch time and sign restoration of product/quotient/remainder.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: shift-add multiply and
// restoring divide on magnitudes, one bit per cycle, sign fix-up at the end.
module muldiv_unit
  import mips_funct::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 6,
  parameter int NB_CNT  = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [NB_OP-1:0]   i_op,
  input  logic [NB_DATA-1:0] i_datoA,
  input  logic [NB_DATA-1:0] i_datoB,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_div_by_zero,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  localparam int                NB_ACC    = 2 * NB_DATA;
  localparam logic [NB_CNT-1:0] LAST_ITER = NB_CNT'(NB_DATA - 1);

  muldiv_state_e      r_state, w_next_state;
  logic [NB_CNT-1:0]  r_cnt;
  logic [NB_ACC-1:0]  r_acc;
  logic [NB_DATA-1:0] r_opnd, r_dividend, r_hi, r_lo;
  logic               r_is_div, r_neg_res, r_neg_rem, r_dbz;

  logic               w_is_signed, w_is_mul, w_is_div, w_last;
  logic [NB_DATA-1:0] w_mag_a, w_mag_b, w_quo_fix, w_rem_fix;
  logic [NB_ACC-1:0]  w_prod_fix, w_mul_next, w_div_next;
  logic [NB_DATA:0]   w_mul_sum, w_div_rem_sh, w_div_diff;

  assign w_is_signed = is_signed_op(i_op);
  assign w_is_mul    = (i_op == MULT_OP) || (i_op == MULTU_OP);
  assign w_is_div    = (i_op == DIV_OP)  || (i_op == DIVU_OP);
  assign w_last      = (r_cnt == LAST_ITER);

  muldiv_signfix #(.W(NB_DATA)) u_mag_a (
    .i_val(i_datoA), .i_neg(w_is_signed & i_datoA[NB_DATA-1]), .o_val(w_mag_a));
  muldiv_signfix #(.W(NB_DATA)) u_mag_b (
    .i_val(i_datoB), .i_neg(w_is_signed & i_datoB[NB_DATA-1]), .o_val(w_mag_b));
  muldiv_signfix #(.W(NB_ACC)) u_fix_prod (
    .i_val(r_acc), .i_neg(r_neg_res), .o_val(w_prod_fix));
  muldiv_signfix #(.W(NB_DATA)) u_fix_quo (
    .i_val(r_acc[NB_DATA-1:0]), .i_neg(r_neg_res), .o_val(w_quo_fix));
  muldiv_signfix #(.W(NB_DATA)) u_fix_rem (
    .i_val(r_acc[NB_ACC-1:NB_DATA]), .i_neg(r_neg_rem), .o_val(w_rem_fix));

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  assign w_mul_sum  = {1'b0, r_acc[NB_ACC-1:NB_DATA]} + {1'b0, r_opnd};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[NB_DATA-1:1]}
                               : {1'b0, r_acc[NB_ACC-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient}; borrow keeps the old remainder.
  assign w_div_rem_sh = r_acc[NB_ACC-1:NB_DATA-1];
  assign w_div_diff   = w_div_rem_sh - {1'b0, r_opnd};
  assign w_div_next   = w_div_diff[NB_DATA]
                        ? {w_div_rem_sh[NB_DATA-1:0], r_acc[NB_DATA-2:0], 1'b0}
                        : {w_div_diff[NB_DATA-1:0],   r_acc[NB_DATA-2:0], 1'b1};

  // NOTE: state and datapath flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_next_state = r_state;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start && w_is_mul)      w_next_state = ST_MUL;
        else if (i_start && w_is_div) w_next_state = ST_DIV;
      end
      ST_MUL, ST_DIV: if (w_last) w_next_state = ST_FIX;
      ST_FIX:  w_next_state = ST_DONE;
      ST_DONE: begin
        o_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_dividend <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (w_is_mul) begin
              r_opnd    <= w_mag_a;
              r_acc     <= {{NB_DATA{1'b0}}, w_mag_b};
              r_neg_res <= w_is_signed & (i_datoA[NB_DATA-1] ^ i_datoB[NB_DATA-1]);
              r_neg_rem <= 1'b0;
              r_is_div  <= 1'b0;
              r_dbz     <= 1'b0;
              r_cnt     <= '0;
            end else if (w_is_div) begin
              r_opnd     <= w_mag_b;
              r_acc      <= {{NB_DATA{1'b0}}, w_mag_a};
              r_dividend <= i_datoA;
              r_neg_res  <= w_is_signed & (i_datoA[NB_DATA-1] ^ i_datoB[NB_DATA-1]);
              r_neg_rem  <= w_is_signed & i_datoA[NB_DATA-1];
              r_is_div   <= 1'b1;
              r_dbz      <= (i_datoB == '0);
              r_cnt      <= '0;
            end else if (i_op == MTHI_OP) begin
              r_hi <= i_datoA;
            end else if (i_op == MTLO_OP) begin
              r_lo <= i_datoA;
            end
          end
        end
        ST_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + NB_CNT'(1);
        end
        ST_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + NB_CNT'(1);
        end
        ST_FIX: begin
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_prod_fix;
          end else if (r_dbz) begin
            r_hi <= r_dividend;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_div_by_zero = (r_state == ST_DONE) & r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized ops
// against an arithmetic reference model, and handshake/reset corner cases.
module tb_muldiv_unit;
  import mips_funct::*;

  localparam int NB_DATA = 32;
  localparam int LATENCY = NB_DATA + 1;

  logic        i_clk, i_rst_n, i_start;
  logic [5:0]  i_op;
  logic [31:0] i_datoA, i_datoB;
  logic        o_busy, o_done, o_div_by_zero;
  logic [31:0] o_hi, o_lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.NB_DATA(32), .NB_OP(6), .NB_CNT(6)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
    .i_datoA(i_datoA), .i_datoB(i_datoB), .o_busy(o_busy), .o_done(o_done),
    .o_div_by_zero(o_div_by_zero), .o_hi(o_hi), .o_lo(o_lo));

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic rules of MULT/MULTU/DIV/DIVU.
  function automatic void model(input logic [5:0] op, input logic [31:0] a, b,
                                output logic [31:0] hi, lo, output logic dbz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    hi  = '0;
    lo  = '0;
    case (op)
      MULT_OP:  begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      MULTU_OP: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      DIV_OP, DIVU_OP: begin
        if (b == 32'd0) begin
          dbz = 1'b1;
          hi  = a;
          lo  = 32'hFFFF_FFFF;
        end else begin
          if (op == DIVU_OP) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
          end
          q  = sa / sb;
          r  = sa % sb;
          lo = q[31:0];
          hi = r[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  // poke: 0 none, 1 DIVU start mid-operation, 2 MTHI start in the DONE cycle.
  task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a, b,
                        input logic [31:0] exp_hi, exp_lo, input logic exp_dbz, input int poke);
    logic [31:0] old_hi, old_lo;
    int          lat;
    bit          busy_ok, stable_ok;
    old_hi = o_hi;
    old_lo = o_lo;
    @(negedge i_clk);
    i_start = 1'b1; i_op = op; i_datoA = a; i_datoB = b;
    @(negedge i_clk);
    i_start = 1'b0; i_datoA = $urandom; i_datoB = $urandom;
    busy_ok   = o_busy;
    stable_ok = 1'b1;
    lat       = -1;
    for (int k = 1; k <= LATENCY + 20; k++) begin
      if (poke == 1 && k == 10) begin
        i_start = 1'b1;
        i_op    = DIVU_OP;
      end else begin
        i_start = 1'b0;
      end
      @(negedge i_clk);
      if (o_done) begin
        lat = k;
        break;
      end
      if (!o_busy) busy_ok = 1'b0;
      if (o_hi !== old_hi || o_lo !== old_lo) stable_ok = 1'b0;
    end
    check({name, " latency"}, 64'(lat), 64'(LATENCY));
    check({name, " busy"}, 64'(busy_ok), 64'd1);
    check({name, " hilo stable"}, 64'(stable_ok), 64'd1);
    check({name, " hi"}, 64'(o_hi), 64'(exp_hi));
    check({name, " lo"}, 64'(o_lo), 64'(exp_lo));
    check({name, " dbz"}, 64'(o_div_by_zero), 64'(exp_dbz));
    if (poke == 2) begin
      i_start = 1'b1; i_op = MTHI_OP; i_datoA = 32'hDEAD_BEEF;
    end
    @(negedge i_clk);
    i_start = 1'b0;
    check({name, " idle done"}, 64'(o_done), 64'd0);
    check({name, " idle busy"}, 64'(o_busy), 64'd0);
    check({name, " idle dbz"}, 64'(o_div_by_zero), 64'd0);
    if (poke == 2) check({name, " done-cycle start ignored"}, 64'(o_hi), 64'(exp_hi));
  endtask

  task automatic move_to(input logic [5:0] op, input logic [31:0] val);
    @(negedge i_clk);
    i_start = 1'b1; i_op = op; i_datoA = val;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  vec_t        vecs[12];
  logic [5:0]  rand_ops[4];
  logic [5:0]  r_op;
  logic [31:0] ra, rb, ehi, elo;
  logic        edbz;
  bit          saw_done;

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_op = '0; i_datoA = '0; i_datoB = '0;
    repeat (3) @(negedge i_clk);
    check("reset busy", 64'(o_busy), 64'd0);
    check("reset done", 64'(o_done), 64'd0);
    check("reset dbz", 64'(o_div_by_zero), 64'd0);
    check("reset hi", 64'(o_hi), 64'd0);
    check("reset lo", 64'(o_lo), 64'd0);
    i_rst_n = 1'b1;

    vecs[0]  = '{MULT_OP,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[1]  = '{MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2]  = '{MULT_OP,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[3]  = '{DIV_OP,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4]  = '{DIVU_OP,  32'd7,         32'd2,        32'd1,         32'd3,         1'b0};
    vecs[5]  = '{DIV_OP,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6]  = '{DIVU_OP,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{DIV_OP,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[8]  = '{MULT_OP,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[9]  = '{DIVU_OP,  32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{DIV_OP,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[11] = '{MULTU_OP, 32'd0,         32'h1234_5678, 32'd0,         32'd0,         1'b0};

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dbz, (i < 3) ? i : 0);
    end

    rand_ops = '{MULT_OP, MULTU_OP, DIV_OP, DIVU_OP};
    for (int i = 0; i < 24; i++) begin
      r_op = rand_ops[$urandom_range(3, 0)];
      ra   = $urandom;
      rb   = ($urandom_range(7, 0) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(3, 0) == 0) rb = rb >> $urandom_range(31, 16);
      model(r_op, ra, rb, ehi, elo, edbz);
      run_op($sformatf("rand%0d", i), r_op, ra, rb, ehi, elo, edbz, i % 3);
    end

    move_to(MTHI_OP, 32'h1234_5678);
    check("mthi hi", 64'(o_hi), 64'h1234_5678);
    check("mthi busy", 64'(o_busy), 64'd0);
    check("mthi done", 64'(o_done), 64'd0);
    move_to(MTLO_OP, 32'hCAFE_F00D);
    check("mtlo lo", 64'(o_lo), 64'hCAFE_F00D);
    check("mtlo keeps hi", 64'(o_hi), 64'h1234_5678);

    @(negedge i_clk);
    i_start = 1'b1; i_op = DIV_OP; i_datoA = 32'd100; i_datoB = 32'd3;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (10) @(negedge i_clk);
    check("pre-reset busy", 64'(o_busy), 64'd1);
    i_rst_n = 1'b0;
    #1;
    check("abort busy", 64'(o_busy), 64'd0);
    check("abort hi", 64'(o_hi), 64'd0);
    check("abort lo", 64'(o_lo), 64'd0);
    check("abort done", 64'(o_done), 64'd0);
    @(negedge i_clk);
    i_rst_n  = 1'b1;
    saw_done = 1'b0;
    repeat (LATENCY + 8) begin
      @(negedge i_clk);
      if (o_done || o_busy) saw_done = 1'b1;
    end
    check("no done after abort", 64'(saw_done), 64'd0);

    run_op("post-reset", DIVU_OP, 32'd100, 32'd3, 32'd1, 32'd33, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit for the MIPS EX stage. It owns the HI/LO register pair and executes the R-type funct codes the single-cycle ALU does not: MULT, MULTU, DIV, DIVU, MTHI and MTLO. The control path issues an operation with a start/busy/done handshake and stalls on o_busy. o_hi and o_lo feed the MFHI/MFLO read path.

Parameters:
NB_DATA, 32, operand width and HI/LO width
NB_OP, 6, funct field width
NB_CNT, 6, iteration counter width (must hold NB_DATA)

Ports:
i_clk  input  1  clock, rising-edge active
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  issue request, sampled only when idle
i_op  input  NB_OP  funct code: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011
i_datoA  input  NB_DATA  rs operand (multiplicand / dividend / MTHI-MTLO source)
i_datoB  input  NB_DATA  rt operand (multiplier / divisor)
o_busy  output  1  operation in progress
o_done  output  1  one-cycle pulse; HI/LO hold the new result
o_div_by_zero  output  1  pulses with o_done when the divisor was 0
o_hi  output  NB_DATA  HI register
o_lo  output  NB_DATA  LO register

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_busy=0, o_done=0, o_div_by_zero=0, o_hi=0, o_lo=0; counter and working registers cleared. Reset mid-operation aborts the operation immediately; no done pulse follows.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, edge with i_start=1:
  - MULT/MULTU: latch operand magnitudes, or raw values for the unsigned form; latch the sign of the result; go to MUL.
  - DIV/DIVU: same latching; go to DIV.
  - MTHI: o_hi <= i_datoA. MTLO: o_lo <= i_datoA. Stay IDLE; no busy, no done.
  - Any other funct: ignored.
- MUL: shift-add, one multiplier bit per cycle, 2*NB_DATA accumulator; exactly NB_DATA cycles, then FIX.
- DIV: restoring division, one quotient bit per cycle; exactly NB_DATA cycles, then FIX.
- FIX (1 cycle):
  - Signed ops: apply two's-complement negation to the product, or to quotient/remainder.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Write o_hi/o_lo: product high/low, or remainder/quotient. Go to DONE.
- DONE (1 cycle): o_done=1, then IDLE.
- o_busy=1 in MUL, DIV, FIX and DONE.
- Latency: if the accept edge is E0, o_hi/o_lo update at E(NB_DATA+1) and o_done is high for the cycle after it. That is 33 edges for 32-bit operands.
- o_hi/o_lo are stable during busy and keep old values until FIX.
- i_start while busy: ignored, not queued. i_start in the DONE cycle: also ignored. The earliest new accept is the first IDLE cycle.
- Divide by zero (i_datoB=0, DIV or DIVU): full latency; result forced to o_lo=32'hFFFFFFFF, o_hi=i_datoA as latched; o_div_by_zero=1 with o_done.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: o_lo=0x80000000, o_hi=0; no flag.
- Operands are latched at accept; later input changes have no effect.

Decomposition:
- Shared package/header mips_funct: funct localparams (MULT_OP, MULTU_OP, DIV_OP, DIVU_OP, MTHI_OP, MTLO_OP, together with the existing ALU op codes) and the state encoding.
- One natural sub-module: muldiv_signfix, a combinational magnitude/negation helper used at latch and in FIX.
- Everything else is a single FSM plus datapath in muldiv_unit.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=5 -> o_hi=0xFFFFFFFF, o_lo=0xFFFFFFF1; o_done exactly 33 cycles after accept; o_busy high throughout.
- MULTU A=B=0xFFFFFFFF -> o_hi=0xFFFFFFFE, o_lo=0x00000001; MULT on the same operands -> o_hi=0, o_lo=1.
- DIV A=0xFFFFFFF9 (-7), B=2 -> o_lo=0xFFFFFFFD, o_hi=0xFFFFFFFF; DIVU 7/2 -> o_lo=3, o_hi=1; DIV 0x80000000/0xFFFFFFFF -> o_lo=0x80000000, o_hi=0.
- DIVU A=7, B=0 -> o_div_by_zero=1 with o_done; o_lo=0xFFFFFFFF, o_hi=7.
- MULT in flight, second i_start with DIVU mid-operation -> ignored, MULT result intact. Then MTHI A=0x12345678 -> o_hi=0x12345678 next edge, no done. Then i_rst_n pulsed low mid-DIV -> o_busy, o_hi, o_lo all 0 immediately; no o_done.
